// File: rtl/repair_lane_eval_if.sv
// ---------------------------------------------------------------------------
// repair_lane_eval_if
//   Groups every functional signal of repair_lane_eval: the MBTRAIN-side
//   enable and point-test results, and the repair-wrapper handshake.
//   Clock and reset stay plain ports on the module.
//
//   i_en                             start/hold from MBTRAIN, low aborts
//   i_lane_result[15:0]              per-lane pass flags (1 = pass)
//   i_lane_result_valid              qualifies i_lane_result for one cycle
//   i_test_ack                       repair-exchange completion
//   i_remote_first_8_result          remote partner verdict, lanes 0-7
//   i_remote_second_8_result         remote partner verdict, lanes 8-15
//   o_repair_en                      enable to the repair wrapper
//   o_first_8_lanes_are_functional   local verdict, lanes 0-7
//   o_second_8_lanes_are_functional  local verdict, lanes 8-15
//   o_lane_map[2:0]                  final width (011 x16, 001 lo, 010 hi)
//   o_done                           evaluation complete
//   o_error                          no usable half
//   o_timeout                        repair handshake timed out
//
//   master : drives the i_* signals (MBTRAIN / repair wrapper side)
//   slave  : the evaluator itself
// ---------------------------------------------------------------------------
interface repair_lane_eval_if;
  logic        i_en;
  logic [15:0] i_lane_result;
  logic        i_lane_result_valid;
  logic        i_test_ack;
  logic        i_remote_first_8_result;
  logic        i_remote_second_8_result;
  logic        o_repair_en;
  logic        o_first_8_lanes_are_functional;
  logic        o_second_8_lanes_are_functional;
  logic [2:0]  o_lane_map;
  logic        o_done;
  logic        o_error;
  logic        o_timeout;

  modport master (
    output i_en, i_lane_result, i_lane_result_valid, i_test_ack,
           i_remote_first_8_result, i_remote_second_8_result,
    input  o_repair_en, o_first_8_lanes_are_functional,
           o_second_8_lanes_are_functional, o_lane_map, o_done, o_error,
           o_timeout
  );

  modport slave (
    input  i_en, i_lane_result, i_lane_result_valid, i_test_ack,
           i_remote_first_8_result, i_remote_second_8_result,
    output o_repair_en, o_first_8_lanes_are_functional,
           o_second_8_lanes_are_functional, o_lane_map, o_done, o_error,
           o_timeout
  );
endinterface

// File: rtl/repair_lane_eval.sv
// ---------------------------------------------------------------------------
// repair_lane_eval
//   Accumulates NUM_ITER per-lane point-test results, decides which 8-lane
//   halves are usable locally, exchanges that verdict with the remote partner
//   through the repair wrapper and reports the final link width.
//
// Ports
//   clk    functional clock
//   rst_n  asynchronous active-low reset
//   bus    repair_lane_eval_if.slave (see interface file for signal list)
//
// Parameters
//   NUM_ITER        samples ANDed together before evaluation (1..255)
//   TIMEOUT_CYCLES  cycles allowed in REPAIR before giving up
//
// Configuration
//   REPAIR_TIMEOUT_EN  when defined, REPAIR is bounded by TIMEOUT_CYCLES and
//                      an expiry reports o_timeout/o_error with no lanes.
//                      When undefined, REPAIR waits for i_test_ack forever
//                      and o_timeout is tied low.
// ---------------------------------------------------------------------------
module repair_lane_eval #(
  parameter int NUM_ITER       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               rst_n,
  repair_lane_eval_if.slave bus
);

  typedef enum logic [2:0] {IDLE, COLLECT, EVAL, REPAIR, DONE} state_t;

  localparam logic [7:0] NUM_SAMPLES = 8'(NUM_ITER);
  localparam logic [7:0] LAST_SAMPLE = 8'(NUM_ITER - 1);

  // Elaboration-time guard on the parameter ranges.
  if (NUM_ITER < 1 || NUM_ITER > 255 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("repair_lane_eval: NUM_ITER or TIMEOUT_CYCLES out of range");
  end

  state_t      state;
  state_t      state_nxt;
  logic [15:0] acc;
  logic [7:0]  sample_cnt;
  logic        sample_take;
  logic        first_local;
  logic        second_local;
  logic [2:0]  lane_map;
  logic        error_q;
  logic        first_final;
  logic        second_final;

  // A sample only counts while collecting and only until NUM_ITER have been
  // taken; the state leaves COLLECT on the last one, so the counter guard is
  // a second line of defence against late valid pulses.
  assign sample_take = (state == COLLECT) && bus.i_lane_result_valid &&
                       (sample_cnt < NUM_SAMPLES);

  // Final per-half result is the local verdict qualified by the partner's.
  assign first_final  = first_local  & bus.i_remote_first_8_result;
  assign second_final = second_local & bus.i_remote_second_8_result;

`ifdef REPAIR_TIMEOUT_EN
  localparam int             TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] to_cnt;
  logic            timeout_q;
  logic            to_expire;

  // Expiry fires in the TIMEOUT_CYCLES-th REPAIR cycle if no ack came; an
  // ack in that same cycle still wins.
  assign to_expire = (state == REPAIR) && !bus.i_test_ack && (to_cnt == TO_LAST);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. Leaving COLLECT happens on the edge that takes the
  // final sample so that o_repair_en rises two edges after that sample.
  // Dropping i_en overrides everything and returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.i_en) state_nxt = COLLECT;
      COLLECT: if (sample_take && (sample_cnt == LAST_SAMPLE)) state_nxt = EVAL;
      EVAL:    state_nxt = REPAIR;
      REPAIR: begin
        if (bus.i_test_ack) begin
          state_nxt = DONE;
`ifdef REPAIR_TIMEOUT_EN
        end else if (to_expire) begin
          state_nxt = DONE;
`endif
        end
      end
      DONE:    state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
    if (!bus.i_en) state_nxt = IDLE;
  end

  // Datapath: accumulator, sample counter, local verdicts and the final
  // result registers. Everything is cleared whenever i_en is low so that an
  // aborted run leaves no trace in the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= 16'hFFFF;
      sample_cnt   <= 8'd0;
      first_local  <= 1'b0;
      second_local <= 1'b0;
      lane_map     <= 3'b000;
      error_q      <= 1'b0;
`ifdef REPAIR_TIMEOUT_EN
      to_cnt       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else if (!bus.i_en) begin
      acc          <= 16'hFFFF;
      sample_cnt   <= 8'd0;
      first_local  <= 1'b0;
      second_local <= 1'b0;
      lane_map     <= 3'b000;
      error_q      <= 1'b0;
`ifdef REPAIR_TIMEOUT_EN
      to_cnt       <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          acc        <= 16'hFFFF;
          sample_cnt <= 8'd0;
        end
        COLLECT: begin
          if (sample_take) begin
            acc        <= acc & bus.i_lane_result;
            sample_cnt <= sample_cnt + 8'd1;
          end
        end
        EVAL: begin
          first_local  <= &acc[7:0];
          second_local <= &acc[15:8];
`ifdef REPAIR_TIMEOUT_EN
          to_cnt       <= '0;
`endif
        end
        REPAIR: begin
          if (bus.i_test_ack) begin
            lane_map <= {1'b0, second_final, first_final};
            error_q  <= ~first_final & ~second_final;
`ifdef REPAIR_TIMEOUT_EN
          end else if (to_expire) begin
            lane_map  <= 3'b000;
            error_q   <= 1'b1;
            timeout_q <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.o_repair_en                     = (state == REPAIR);
  assign bus.o_done                          = (state == DONE);
  assign bus.o_first_8_lanes_are_functional  = first_local;
  assign bus.o_second_8_lanes_are_functional = second_local;
  assign bus.o_lane_map                      = lane_map;
  assign bus.o_error                         = error_q;
`ifdef REPAIR_TIMEOUT_EN
  assign bus.o_timeout                       = timeout_q;
`else
  assign bus.o_timeout                       = 1'b0;
`endif

endmodule

// File: doc/repair_lane_eval.md
REPAIR_LANE_EVAL -- requirements
Module: repair_lane_eval

Interface
REQ-001 The block SHALL have parameter NUM_ITER, default 4: number of per-lane result samples accumulated before evaluation (range 1..255).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles spent waiting for the repair handshake (used only under REQ-030).
REQ-003 clk  in  1  single functional clock.
REQ-004 rst_n  in  1  asynchronous active-low reset.
REQ-005 i_en  in  1  start/hold from MBTRAIN; deassertion aborts.
REQ-006 i_lane_result  in  16  per-lane pass flags from point test, 1 = pass.
REQ-007 i_lane_result_valid  in  1  qualifies i_lane_result for one cycle.
REQ-008 i_test_ack  in  1  repair-exchange completion from the repair wrapper.
REQ-009 i_remote_first_8_result, i_remote_second_8_result  in  1 each  remote partner half results from the repair wrapper.
REQ-010 o_repair_en  out  1  enable to the repair wrapper.
REQ-011 o_first_8_lanes_are_functional, o_second_8_lanes_are_functional  out  1 each  local half verdicts to the repair wrapper.
REQ-012 o_lane_map  out  3  final width: 3'b011 x16, 3'b001 lanes 0-7, 3'b010 lanes 8-15, 3'b000 none.
REQ-013 o_done  out  1  evaluation complete, o_lane_map valid.
REQ-014 o_error  out  1  no usable half.
REQ-015 o_timeout  out  1  repair handshake timed out.

Function
REQ-016 FSM states SHALL be IDLE, COLLECT, EVAL, REPAIR, DONE.
REQ-017 IDLE -> COLLECT on i_en=1; in the entry cycle the 16-bit pass accumulator SHALL be set to all ones and the sample counter to 0.
REQ-018 In COLLECT, each cycle with i_lane_result_valid=1 SHALL AND i_lane_result into the accumulator and increment the sample counter; cycles without valid SHALL hold both.
REQ-019 COLLECT -> EVAL in the cycle after the sample counter reaches NUM_ITER; valid pulses arriving after the NUM_ITER-th sample SHALL be ignored.
REQ-020 EVAL SHALL last exactly one cycle and register o_first_8_lanes_are_functional = &acc[7:0], o_second_8_lanes_are_functional = &acc[15:8]; then -> REPAIR.
REQ-021 In REPAIR o_repair_en SHALL be 1; the local verdicts SHALL be held stable for the whole state.
REQ-022 On i_test_ack=1 in REPAIR the block SHALL capture the remote results, drop o_repair_en the next cycle and go to DONE.
REQ-023 The half result SHALL be local AND remote per half; o_lane_map = {1'b0, second_ok, first_ok}; o_error = 1 when both halves fail.
REQ-024 In DONE o_done SHALL be 1 and o_lane_map, o_error, o_timeout held until i_en=0, then -> IDLE with all outputs cleared next cycle.
REQ-025 i_en=0 in any state SHALL return to IDLE in the next cycle, clearing all outputs and counters; partial accumulations SHALL be discarded.
REQ-026 i_test_ack outside REPAIR SHALL be ignored; i_lane_result_valid outside COLLECT SHALL be ignored.
REQ-027 Latency from the NUM_ITER-th valid sample to o_repair_en=1 SHALL be 2 cycles.

Reset
REQ-028 On rst_n=0 the FSM SHALL enter IDLE asynchronously and every output SHALL be 0, accumulator all ones, counters 0.
REQ-029 Reset deassertion mid-operation SHALL restart only via a fresh i_en rising from IDLE (i_en held 1 through reset starts COLLECT on the first clock after release).

Configuration
REQ-030 With REPAIR_TIMEOUT_EN defined, a counter SHALL run in REPAIR; reaching TIMEOUT_CYCLES without i_test_ack SHALL force DONE with o_timeout=1, o_error=1, o_lane_map=3'b000, o_repair_en=0.
REQ-031 Without REPAIR_TIMEOUT_EN, REPAIR SHALL wait indefinitely for i_test_ack and o_timeout SHALL be tied to 0.

Verification
REQ-032 4 valid samples 16'hFFFF, ack with remote 1/1 -> o_repair_en 2 cycles after 4th sample, both verdicts 1, o_lane_map=3'b011, o_done=1.
REQ-033 Samples FFFF, FFFE, FFFF, FFFF, remote 1/1 -> first verdict 0, second 1, o_lane_map=3'b010.
REQ-034 Local both pass, remote first=1 second=0 -> o_lane_map=3'b001, o_error=0.
REQ-035 Samples 16'hFEFE -> both verdicts 0, after ack o_lane_map=3'b000, o_error=1.
REQ-036 i_en dropped after 2 samples, then reasserted with 4 samples FFFF -> first run discarded, o_lane_map=3'b011.
REQ-037 REPAIR_TIMEOUT_EN defined, no ack -> after 1024 REPAIR cycles o_timeout=1, o_error=1, o_repair_en=0; undefined -> o_repair_en stays 1.
